// File: rtl/mem_access_ctrl_if.sv
// Request/response and RAM-side bus of the memory access controller.
// The controller is the RAM bus master; the slave modport is the view of
// everything it talks to (the requesting datapath and the RAM itself).
interface mem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 3
);
    // Request side
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] wdata;
    logic              wdata_ready;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              busy;
    logic              done;

    // RAM side
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  req, we, addr, len, wdata, mem_rdata,
        output wdata_ready, rdata, rdata_valid, busy, done,
        output mem_addr, mem_read, mem_write, mem_wdata
    );

    modport slave (
        output req, we, addr, len, wdata, mem_rdata,
        input  wdata_ready, rdata, rdata_valid, busy, done,
        input  mem_addr, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Initiator for a 512x32 synchronous RAM with a registered read port.
// Runs single or burst (1..8 beat) loads and stores with fixed cycle timing:
// one beat issued per cycle, read data captured two edges after issue, and a
// one-cycle done pulse on the final beat.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 3
) (
    input logic               clk,
    input logic               clr_n,
    mem_access_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StRdrain,
        StWrite
    } state_e;

    state_e state_q, state_d;

    // Beats still to issue after the one currently on the RAM bus.
    logic [LEN_W-1:0]  rem_q, rem_d;
    // The RAM sampled a read at the previous edge, so mem_rdata is valid now.
    logic              pend_q, pend_d;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wdata_ready_q, wdata_ready_d;

    // State register; reset aborts any burst immediately.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    state_d = bus.we ? StWrite : StRead;
                end
            end
            StRead: begin
                if (rem_q == '0) begin
                    state_d = StRdrain;
                end
            end
            StRdrain: begin
                state_d = StIdle;
            end
            StWrite: begin
                if (rem_q == '0) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Next values of the registered bus outputs and the beat bookkeeping.
    always_comb begin
        rem_d         = rem_q;
        pend_d        = mem_read_q;
        mem_addr_d    = mem_addr_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_wdata_d   = mem_wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        wdata_ready_d = wdata_ready_q;

        // Capture only when a read was actually sampled, never junk between reads.
        if (pend_q) begin
            rdata_d       = bus.mem_rdata;
            rdata_valid_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                // IDLE is entered together with done, so busy falls one edge
                // later unless a back-to-back request is taken at that edge.
                busy_d        = 1'b0;
                mem_read_d    = 1'b0;
                mem_write_d   = 1'b0;
                wdata_ready_d = 1'b0;
                if (bus.req) begin
                    busy_d     = 1'b1;
                    mem_addr_d = bus.addr;
                    rem_d      = bus.len;
                    if (bus.we) begin
                        mem_write_d   = 1'b1;
                        mem_wdata_d   = bus.wdata;
                        wdata_ready_d = (bus.len != '0);
                    end else begin
                        mem_read_d = 1'b1;
                    end
                end
            end
            StRead: begin
                if (rem_q == '0) begin
                    mem_read_d = 1'b0;
                end else begin
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                    rem_d      = rem_q - LEN_W'(1);
                end
            end
            StRdrain: begin
                // The last beat is captured at this edge.
                done_d = 1'b1;
            end
            StWrite: begin
                if (rem_q == '0) begin
                    mem_write_d   = 1'b0;
                    wdata_ready_d = 1'b0;
                    done_d        = 1'b1;
                end else begin
                    mem_addr_d    = mem_addr_q + ADDR_W'(1);
                    mem_wdata_d   = bus.wdata;
                    rem_d         = rem_q - LEN_W'(1);
                    wdata_ready_d = (rem_q != LEN_W'(1));
                end
            end
            default: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // Registered outputs and counters; all cleared by reset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rem_q         <= '0;
            pend_q        <= 1'b0;
            mem_addr_q    <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_wdata_q   <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            wdata_ready_q <= 1'b0;
        end else begin
            rem_q         <= rem_d;
            pend_q        <= pend_d;
            mem_addr_q    <= mem_addr_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            wdata_ready_q <= wdata_ready_d;
        end
    end

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.wdata_ready = wdata_ready_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural RAM, a shadow memory plus per-cycle
// timing table as reference, directed scenarios followed by random bursts.
module tb_mem_access_ctrl;
    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 32;
    localparam int unsigned LW    = 3;
    localparam int unsigned DEPTH = 512;

    logic clk;
    logic clr_n;
    int   n_cmp;
    int   n_bad;

    mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] init_word(input int i);
        logic [DW-1:0] v;
        v = DW'(i);
        return 32'hC0DE_0000 | v;
    endfunction

    // Behavioural RAM: registered read port, junk on mem_rdata outside reads.
    logic [DW-1:0] ram [DEPTH];
    bit            ram_loaded;
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < int'(DEPTH); i++) ram[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else begin
            if (bd_we) ram[bd_addr] <= bd_data;
            if (bus.mem_write) ram[bus.mem_addr] <= bus.mem_wdata;
        end
        if (bus.mem_read) bus.mem_rdata <= ram[bus.mem_addr];
        else bus.mem_rdata <= $urandom();
    end

    // Reference: expected memory contents after every store issued so far.
    logic [DW-1:0] shadow [DEPTH];

    logic          p_we, c_we;
    logic [AW-1:0] p_addr, c_addr;
    logic [LW-1:0] p_len, c_len;
    logic [DW-1:0] pbuf [8];
    logic [DW-1:0] cbuf [8];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h, expected %08h", tag, obs, exp);
        end
    endtask

    // Never both strobes at once.
    always @(negedge clk) chk1("rd_wr_exclusive", bus.mem_read & bus.mem_write, 1'b0);

    task automatic check_all_zero(input string tag);
        chkw({tag, " rdata"}, bus.rdata, 32'd0);
        chk1({tag, " rdata_valid"}, bus.rdata_valid, 1'b0);
        chk1({tag, " busy"}, bus.busy, 1'b0);
        chk1({tag, " done"}, bus.done, 1'b0);
        chk1({tag, " wdata_ready"}, bus.wdata_ready, 1'b0);
        chkw({tag, " mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk1({tag, " mem_read"}, bus.mem_read, 1'b0);
        chk1({tag, " mem_write"}, bus.mem_write, 1'b0);
        chkw({tag, " mem_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [31:0] r;
        r = 32'h1F0 + $urandom_range(31, 0);
        return AW'(r);
    endfunction

    task automatic prep_txn(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
        p_we   = w;
        p_addr = a;
        p_len  = l;
        for (int i = 0; i < 8; i++) pbuf[i] = $urandom();
    endtask

    task automatic drive_pending();
        bus.req   = 1'b1;
        bus.we    = p_we;
        bus.addr  = p_addr;
        bus.len   = p_len;
        bus.wdata = pbuf[0];
    endtask

    // Runs the already-driven request; t counts edges after the accepting edge.
    // Store of L+1 beats: done after e(L+1). Load: done with last beat after e(L+2).
    task automatic run_txn(input bit noise, input bit chain, input logic nw,
                           input logic [AW-1:0] na, input logic [LW-1:0] nl);
        int            len_i;
        int            t_done;
        int            noise_t;
        logic [AW-1:0] ea;
        c_we   = p_we;
        c_addr = p_addr;
        c_len  = p_len;
        for (int i = 0; i < 8; i++) cbuf[i] = pbuf[i];
        len_i   = int'(c_len);
        t_done  = c_we ? len_i + 1 : len_i + 2;
        noise_t = noise ? int'($urandom_range(unsigned'(t_done - 1), 0)) : -1;
        if (c_we) begin
            for (int i = 0; i <= len_i; i++) begin
                ea = c_addr + AW'(i);
                shadow[ea] = cbuf[i];
            end
        end
        if (chain) prep_txn(nw, na, nl);
        for (int t = 0; t <= t_done; t++) begin
            @(posedge clk);
            #1;
            bus.req = 1'b0;
            chk1($sformatf("busy t=%0d", t), bus.busy, 1'b1);
            chk1($sformatf("done t=%0d", t), bus.done, t == t_done);
            if (c_we) begin
                chk1($sformatf("wr rdata_valid t=%0d", t), bus.rdata_valid, 1'b0);
                chk1($sformatf("wr mem_write t=%0d", t), bus.mem_write, t <= len_i);
                chk1($sformatf("wr mem_read t=%0d", t), bus.mem_read, 1'b0);
                chk1($sformatf("wdata_ready t=%0d", t), bus.wdata_ready, t < len_i);
                if (t <= len_i) begin
                    ea = c_addr + AW'(t);
                    chkw($sformatf("wr mem_addr t=%0d", t), 32'(bus.mem_addr), 32'(ea));
                    chkw($sformatf("wr mem_wdata t=%0d", t), bus.mem_wdata, cbuf[t]);
                end
                if (t + 1 <= len_i) bus.wdata = cbuf[t + 1];
                else bus.wdata = $urandom();
            end else begin
                chk1($sformatf("rd rdata_valid t=%0d", t), bus.rdata_valid, t >= 2);
                chk1($sformatf("rd mem_read t=%0d", t), bus.mem_read, t <= len_i);
                chk1($sformatf("rd mem_write t=%0d", t), bus.mem_write, 1'b0);
                chk1($sformatf("rd wdata_ready t=%0d", t), bus.wdata_ready, 1'b0);
                if (t <= len_i) begin
                    ea = c_addr + AW'(t);
                    chkw($sformatf("rd mem_addr t=%0d", t), 32'(bus.mem_addr), 32'(ea));
                end
                if (t >= 2) begin
                    ea = c_addr + AW'(t - 2);
                    chkw($sformatf("rdata t=%0d", t), bus.rdata, shadow[ea]);
                end
            end
            // A request while the burst is still running must be ignored.
            if (t == noise_t) begin
                bus.req  = 1'b1;
                bus.we   = 1'($urandom_range(1, 0));
                bus.addr = AW'($urandom());
                bus.len  = LW'($urandom());
            end
            if (t == t_done && chain) drive_pending();
        end
        if (!chain) begin
            @(posedge clk);
            #1;
            chk1("end busy", bus.busy, 1'b0);
            chk1("end done", bus.done, 1'b0);
            chk1("end rdata_valid", bus.rdata_valid, 1'b0);
            chk1("end mem_read", bus.mem_read, 1'b0);
            chk1("end mem_write", bus.mem_write, 1'b0);
            chk1("end wdata_ready", bus.wdata_ready, 1'b0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time %0t exceeded the run budget", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit            chained;
        bit            nz;
        bit            ch;
        logic          nw;
        logic [AW-1:0] na;
        logic [LW-1:0] nl;
        logic [DW-1:0] w0, w1, w2;

        n_cmp     = 0;
        n_bad     = 0;
        clr_n     = 1'b0;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.len   = '0;
        bus.wdata = '0;
        bd_we     = 1'b0;
        bd_addr   = '0;
        bd_data   = '0;
        for (int i = 0; i < int'(DEPTH); i++) shadow[i] = init_word(i);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        #2 clr_n = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("idle");

        // Single load from a preloaded word
        bd_we   = 1'b1;
        bd_addr = 9'h010;
        bd_data = 32'hDEAD_BEEF;
        shadow[9'h010] = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bd_we = 1'b0;
        prep_txn(1'b0, 9'h010, 3'd0);
        drive_pending();
        run_txn(1'b0, 1'b0, 1'b0, '0, '0);

        // Burst store of four known words, then burst load of the same range
        prep_txn(1'b1, 9'h020, 3'd3);
        pbuf[0] = 32'h11;
        pbuf[1] = 32'h22;
        pbuf[2] = 32'h33;
        pbuf[3] = 32'h44;
        drive_pending();
        run_txn(1'b0, 1'b0, 1'b0, '0, '0);
        prep_txn(1'b0, 9'h020, 3'd3);
        drive_pending();
        run_txn(1'b1, 1'b0, 1'b0, '0, '0);

        // Wrapping store with an ignored mid-burst request, readback taken back-to-back
        prep_txn(1'b1, 9'h1FE, 3'd2);
        w0 = pbuf[0];
        w1 = pbuf[1];
        w2 = pbuf[2];
        drive_pending();
        run_txn(1'b1, 1'b1, 1'b0, 9'h1FE, 3'd2);
        run_txn(1'b1, 1'b0, 1'b0, '0, '0);
        chkw("wrap ram[1FE]", ram[9'h1FE], w0);
        chkw("wrap ram[1FF]", ram[9'h1FF], w1);
        chkw("wrap ram[000]", ram[9'h000], w2);

        // Reset during the third beat of an 8-beat load
        prep_txn(1'b0, 9'h100, 3'd7);
        drive_pending();
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chkw("pre-abort mem_addr", 32'(bus.mem_addr), 32'h102);
        #2 clr_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(posedge clk);
        #1;
        check_all_zero("abort held");
        #2 clr_n = 1'b1;
        prep_txn(1'b0, 9'h000, 3'd0);
        drive_pending();
        run_txn(1'b0, 1'b0, 1'b0, '0, '0);

        // Random bursts in a small wrapping window, with random chaining and noise
        chained = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!chained) begin
                prep_txn(1'($urandom_range(1, 0)), rand_addr(), LW'($urandom()));
                drive_pending();
            end
            nw = 1'($urandom_range(1, 0));
            na = rand_addr();
            nl = LW'($urandom());
            nz = 1'($urandom_range(1, 0));
            ch = (i != 39) && ($urandom_range(1, 0) == 1);
            run_txn(nz, ch, nw, na, nl);
            chained = ch;
            if (!ch) begin
                repeat ($urandom_range(2, 0)) @(posedge clk);
                #1;
            end
        end

        // Whole memory against the shadow
        for (int i = 0; i < int'(DEPTH); i++) begin
            chkw($sformatf("ram[%0d]", i), ram[i], shadow[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
